// File: rtl/vend_stock_keeper.sv
// rtl/vend_stock_keeper.sv - per-item stock counts with dispense decrement and req/ack restock
module vend_stock_keeper #(
    parameter int MAX_STOCK  = 63,
    parameter int LOW_MARK   = 3,
    parameter int INIT_STOCK = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vend_vld,
    input  logic [1:0] vend_item,
    input  logic       svc_mode,
    input  logic       svc_req,
    input  logic [1:0] svc_item,
    input  logic [5:0] svc_qty,
    output logic       svc_ack,
    output logic       busy,
    output logic [5:0] left1,
    output logic [5:0] left2,
    output logic [5:0] left3,
    output logic [2:0] soldout,
    output logic [2:0] lowstock,
    output logic       err,
    output logic       ovf,
    output logic [7:0] sales
);
    typedef enum logic [1:0] {IDLE, VEND, LOAD, ACK} state_t;

    localparam logic [6:0] MAX7  = 7'(MAX_STOCK);
    localparam logic [5:0] MAX6  = 6'(MAX_STOCK);
    localparam logic [5:0] LOW6  = 6'(LOW_MARK);
    localparam logic [5:0] INIT6 = 6'(INIT_STOCK);

    state_t     state;
    logic [1:0] item;
    logic [5:0] qty;
    logic [5:0] cur;
    logic [6:0] sum;
    logic       wr_en;
    logic [5:0] wr_val;

    // Operand is the count of whichever item was latched on entry to VEND/LOAD.
    always_comb begin
        case (item)
            2'd1:    cur = left1;
            2'd2:    cur = left2;
            2'd3:    cur = left3;
            default: cur = 6'd0;
        endcase
        sum    = {1'b0, cur} + {1'b0, qty};
        wr_en  = 1'b0;
        wr_val = cur;
        if (state == VEND && item != 2'd0 && cur != 6'd0) begin
            wr_en  = 1'b1;
            wr_val = cur - 6'd1;
        end else if (state == LOAD && item != 2'd0) begin
            wr_en  = 1'b1;
            wr_val = (sum > MAX7) ? MAX6 : sum[5:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            item    <= 2'd0;
            qty     <= 6'd0;
            left1   <= INIT6;
            left2   <= INIT6;
            left3   <= INIT6;
            sales   <= 8'd0;
            svc_ack <= 1'b0;
            err     <= 1'b0;
            ovf     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            err  <= 1'b0;
            ovf  <= 1'b0;
            busy <= svc_mode;
            if (wr_en) begin
                case (item)
                    2'd1:    left1 <= wr_val;
                    2'd2:    left2 <= wr_val;
                    default: left3 <= wr_val;
                endcase
            end
            case (state)
                IDLE: begin
                    if (vend_vld && !svc_mode) begin
                        item  <= vend_item;
                        state <= VEND;
                        busy  <= 1'b1;
                    end else if (svc_mode && svc_req) begin
                        item  <= svc_item;
                        qty   <= svc_qty;
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                VEND: begin
                    if (wr_en) sales <= sales + 8'd1;
                    else       err   <= 1'b1;
                    state <= IDLE;
                end
                LOAD: begin
                    if (item == 2'd0) err <= 1'b1;
                    else if (sum > MAX7) ovf <= 1'b1;
                    svc_ack <= 1'b1;
                    state   <= ACK;
                    busy    <= 1'b1;
                end
                ACK: begin
                    // Hold ack until the requester drops svc_req so one request loads once.
                    if (!svc_req) begin
                        svc_ack <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        busy <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign soldout  = {left3 == 6'd0, left2 == 6'd0, left1 == 6'd0};
    assign lowstock = {(left3 != 6'd0) && (left3 <= LOW6),
                       (left2 != 6'd0) && (left2 <= LOW6),
                       (left1 != 6'd0) && (left1 <= LOW6)};
endmodule

// File: doc/vend_stock_keeper.md
# vend_stock_keeper

Inventory writer for the vending machine. Owns the per-item stock counts `left1`/`left2`/`left3` that the vending FSM reads in its sold-out check. Decrements the selected item on each dispense event and accepts restock loads from a service port through a req/ack handshake. Also produces sold-out, low-stock, error and sales-count status for the display and service panel.

## Interface
- `MAX_STOCK`, default 63: saturation ceiling for every stock count; must be at most 63.
- `LOW_MARK`, default 3: a low-stock flag is raised when the count is at or below this value and above 0.
- `INIT_STOCK`, default 10: value loaded into each count on reset.
- `clk` in 1: the single clock; every register updates on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `vend_vld` in 1: one-cycle dispense pulse.
- `vend_item` in 2: item code 1, 2 or 3, valid while `vend_vld` is high.
- `svc_mode` in 1: service door open.
- `svc_req` in 1: restock request, level signal.
- `svc_item` in 2: restock item code 1..3.
- `svc_qty` in 6: quantity to add.
- `svc_ack` out 1: restock handshake acknowledge.
- `busy` out 1: high when the state is not IDLE or `svc_mode` is 1. The vending FSM must not dispense while it is high.
- `left1`, `left2`, `left3` out 6 each: current stock per item.
- `soldout` out 3: bit i-1 is high when `left<i>` == 0.
- `lowstock` out 3: bit i-1 is high when 0 < `left<i>` <= `LOW_MARK`.
- `err` out 1: one-cycle pulse on an illegal vend.
- `ovf` out 1: one-cycle pulse on a saturated restock.
- `sales` out 8: total successful vends since reset; wraps 255 -> 0.

## Operation
- States: IDLE, VEND, LOAD, ACK. All outputs are registered.
- IDLE:
  - `vend_vld`=1 and `svc_mode`=0: latch `vend_item` and go to VEND.
  - Otherwise, `svc_mode`=1 and `svc_req`=1: latch `svc_item` and `svc_qty` and go to LOAD.
  - Otherwise stay in IDLE.
- VEND, one cycle, then IDLE:
  - Item is 1..3 and its count > 0: count - 1, `sales` + 1.
  - Item is 0, or the count is 0: no change to any count or to `sales`; `err`=1 for this cycle.
- LOAD, one cycle, then ACK:
  - Item is 1..3: new count = min(count + qty, `MAX_STOCK`). Compute the sum 7 bits wide. If the sum > `MAX_STOCK`, `ovf`=1 for one cycle.
  - Item is 0: no count change; `err`=1 for one cycle.
- ACK: `svc_ack`=1. Stay until `svc_req`=0, then go to IDLE with `svc_ack`=0. Exactly one load happens per request, however long `svc_req` is held.
- Arbitration: a vend wins over a simultaneous restock request in IDLE. The request stays pending and is served after the vend returns to IDLE.
- `vend_vld` is ignored outside IDLE and whenever `svc_mode`=1; such a vend pulse is dropped with no `err`.
- `svc_mode` falling while in LOAD or ACK does not abort the handshake; it completes normally.
- `soldout` and `lowstock` are derived from the registered counts and update in the same cycle as the counts.

## Timing
- Reset values:
  - State IDLE.
  - `left1` = `left2` = `left3` = `INIT_STOCK`.
  - `sales`=0, `svc_ack`=0, `err`=0, `ovf`=0, `busy`=0.
  - `soldout` and `lowstock` take the values that correspond to `INIT_STOCK`.
- `rst` asserted in any state forces the reset values on the next edge. A handshake in progress is abandoned and `svc_ack` drops.
- Vend latency:
  - Pulse sampled at edge N; state = VEND after edge N.
  - Count and `sales` are updated and `err` is valid after edge N+1.
  - `busy` is high for the one cycle between edge N and edge N+1.
- Restock latency:
  - `svc_req` sampled at edge N; LOAD after edge N.
  - Count updated and `svc_ack`=1 after edge N+1.
  - `svc_ack` falls one edge after `svc_req` is sampled low.
- Back-to-back vends: at most one vend per 2 cycles. A pulse arriving while in VEND is dropped.

## Test plan
- Reset with `INIT_STOCK`=10, then vend item 2 three times, 2 cycles apart -> `left2`=7, `sales`=3, `left1`=`left3`=10, `err` never high.
- With `left1`=1: vend item 1 -> `left1`=0, `soldout`[0]=1. Vend item 1 again -> `err` pulses for one cycle, `left1` stays 0, `sales` unchanged.
- `svc_mode`=1, restock item 3 with qty 5 from `left3`=10, `svc_req` held 4 cycles -> `left3`=15 exactly once, `svc_ack` high until 1 cycle after `svc_req` falls.
- Restock item 1 with qty 60 from `left1`=10 -> `left1`=63, `ovf` pulses once.
- `vend_vld` and `svc_req` in the same IDLE cycle, `svc_mode`=0 then 1 (vend first, then service) -> vend is applied first, then restock is applied; `busy` is high throughout the service.
- Assert `rst` while in ACK -> all counts return to 10, `svc_ack`=0, state IDLE; `sales` wraps 255 -> 0 on the 256th vend.
